// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-atomic N:1 AXI-Stream arbiter, one idle bubble per packet.
// Define AXIS_PKT_ARBITER_RR_EN for round-robin; otherwise lowest index wins.
module axis_pkt_arbiter #(
  parameter int N = 4,
  parameter int W = 4,
  parameter int U = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N-1:0]           s_tvalid,
  output logic [N-1:0]           s_tready,
  input  logic [N*8*W-1:0]       s_tdata,
  input  logic [N-1:0]           s_tlast,
  input  logic [N*U-1:0]         s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [8*W-1:0]         m_tdata,
  output logic                   m_tlast,
  output logic [U-1:0]           m_tuser,
  output logic [$clog2(N)-1:0]   m_tid,
  output logic                   busy
);
  localparam int IW = $clog2(N);
  localparam int DW = 8 * W;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, sel;
`ifdef AXIS_PKT_ARBITER_RR_EN
  logic [IW-1:0] last_q;
  int cand;
  // walk offsets from far to near so the requester closest after last_q wins
  always_comb begin
    sel = last_q;
    cand = 0;
    for (int i = N; i >= 1; i--) begin
      cand = int'(last_q) + i;
      if (cand >= N) cand = cand - N;
      if (s_tvalid[cand]) sel = IW'(cand);
    end
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) last_q <= IW'(N - 1);
    else if (state_q == IDLE && |s_tvalid) last_q <= sel;
`else
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--)
      if (s_tvalid[i]) sel = IW'(i);
  end
`endif
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (state_q == IDLE && |s_tvalid) begin
      state_d = GRANT;
      grant_d = sel;
    end else if (state_q == GRANT && m_tvalid && m_tready && m_tlast) state_d = IDLE;
  end
  assign busy     = state_q == GRANT;
  assign m_tvalid = busy & s_tvalid[grant_q];
  assign m_tdata  = s_tdata[int'(grant_q)*DW +: DW];
  assign m_tlast  = s_tlast[grant_q];
  assign m_tuser  = s_tuser[int'(grant_q)*U +: U];
  assign m_tid    = grant_q;
  assign s_tready = busy ? N'(m_tready) << grant_q : '0;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed checks of grant order, backpressure, atomicity and reset.
module tb_axis_pkt_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int U = 1;
  logic aclk = 0, aresetn = 0;
  logic [N-1:0] s_tvalid = '0, s_tready, s_tlast = '0;
  logic [N*8*W-1:0] s_tdata = '0;
  logic [N*U-1:0] s_tuser = '0;
  logic m_tvalid, m_tready = 1, m_tlast, busy;
  logic [8*W-1:0] m_tdata;
  logic [U-1:0] m_tuser;
  logic [1:0] m_tid;
  int vectors = 0, errs = 0;
  int len[N], beat[N], pkt[N], rpt[N];
  bit active[N];
  int ord[$];
  int nxfer = 0;
  logic sb_busy, sb_mv, sb_last, sb_user;
  logic [1:0] sb_tid;
  logic [3:0] sb_str;
  logic [31:0] sb_data;
  bit bp[6] = '{1, 0, 0, 1, 1, 1};
`ifdef AXIS_PKT_ARBITER_RR_EN
  int exp_c2[3] = '{0, 3, 0};
  int exp_all[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
  int exp_c2[3] = '{0, 0, 3};
  int exp_all[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif

  axis_pkt_arbiter #(.N(N), .W(W), .U(U)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input int k, input int p, input int b);
    return {8'(k), 8'(p), 16'(b)};
  endfunction

  function automatic bit any_active();
    bit a = 0;
    for (int k = 0; k < N; k++) a |= active[k];
    return a;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_tvalid[k] = active[k];
      s_tdata[k*32 +: 32] = mkdata(k, pkt[k], beat[k]);
      s_tlast[k] = active[k] && beat[k] == len[k] - 1;
      s_tuser[k] = 1'(beat[k]);
    end
  endtask

  task automatic send(input int k, input int l);
    active[k] = 1;
    len[k] = l;
    beat[k] = 0;
    pkt[k]++;
    drive();
  endtask

  // snapshot outputs mid-cycle, then advance each source past its accepted beat
  task automatic cyc();
    logic [N-1:0] hs;
    @(negedge aclk);
    hs = s_tvalid & s_tready;
    sb_busy = busy; sb_mv = m_tvalid; sb_last = m_tlast; sb_user = m_tuser[0];
    sb_tid = m_tid; sb_str = s_tready; sb_data = m_tdata;
    if (m_tvalid && m_tready) begin
      nxfer++;
      if (m_tlast) ord.push_back(int'(m_tid));
    end
    @(posedge aclk);
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k]) begin
        if (beat[k] == len[k] - 1) begin
          if (rpt[k] > 0) begin
            rpt[k]--;
            beat[k] = 0;
            pkt[k]++;
          end else active[k] = 0;
        end else beat[k]++;
      end
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (busy || any_active()); i++) cyc();
    chk("drain_idle", {busy, any_active()}, 0);
  endtask

  task automatic do_reset();
    aresetn = 0;
    for (int k = 0; k < N; k++) begin
      active[k] = 0;
      rpt[k] = 0;
    end
    drive();
    m_tready = 1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    ord.delete();
    nxfer = 0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      len[k] = 1; beat[k] = 0; pkt[k] = 0; rpt[k] = 0; active[k] = 0;
    end
    drive();
    #2;
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tid", m_tid, 0);
    chk("rst_tready", s_tready, 0);
    do_reset();

    send(2, 3);
    cyc();
    chk("s1_idle_busy", sb_busy, 0);
    chk("s1_idle_mvalid", sb_mv, 0);
    chk("s1_idle_tready", sb_str, 0);
    cyc();
    chk("s1_busy", sb_busy, 1);
    chk("s1_tid", sb_tid, 2);
    chk("s1_tready", sb_str, 4'b0100);
    chk("s1_data0", sb_data, mkdata(2, pkt[2], 0));
    chk("s1_user0", sb_user, 0);
    cyc();
    chk("s1_user1", sb_user, 1);
    chk("s1_data1", sb_data, mkdata(2, pkt[2], 1));
    cyc();
    chk("s1_last", sb_last, 1);
    cyc();
    chk("s1_done_busy", sb_busy, 0);
    chk("s1_xfers", nxfer, 3);

    do_reset();
    send(0, 2);
    send(3, 2);
    drain();
    chk("c1_count", ord.size(), 2);
    if (ord.size() == 2) begin
      chk("c1_first", ord[0], 0);
      chk("c1_second", ord[1], 3);
    end
    do_reset();
    rpt[0] = 1;
    send(0, 2);
    send(3, 2);
    drain();
    chk("c2_count", ord.size(), 3);
    for (int i = 0; i < 3 && i < ord.size(); i++) chk($sformatf("c2_ord%0d", i), ord[i], exp_c2[i]);

    do_reset();
    send(1, 4);
    cyc();
    begin
      int tr = 0;
      for (int i = 0; i < 6; i++) begin
        m_tready = bp[i];
        cyc();
        chk($sformatf("bp_tready%0d", i), sb_str, {2'b00, bp[i], 1'b0});
        chk($sformatf("bp_data%0d", i), sb_data, mkdata(1, pkt[1], tr));
        if (bp[i]) tr++;
      end
    end
    m_tready = 1;
    cyc();
    chk("bp_idle", sb_busy, 0);
    chk("bp_xfers", nxfer, 4);

    do_reset();
    send(1, 3);
    cyc();
    cyc();
    chk("nm_tid0", sb_tid, 1);
    send(3, 1);
    cyc();
    chk("nm_tid1", sb_tid, 1);
    chk("nm_tready1", sb_str, 4'b0010);
    cyc();
    chk("nm_tid2", sb_tid, 1);
    chk("nm_last", sb_last, 1);
    cyc();
    chk("nm_gap", sb_busy, 0);
    cyc();
    chk("nm_p3_busy", sb_busy, 1);
    chk("nm_p3_tid", sb_tid, 3);
    drain();

    do_reset();
    send(2, 5);
    cyc();
    cyc();
    #2 aresetn = 0;
    #1;
    chk("rs_mvalid", m_tvalid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_tready", s_tready, 0);
    active[2] = 0;
    drive();
    @(posedge aclk);
    #1 aresetn = 1;
    send(1, 1);
    cyc();
    chk("rs_idle", sb_busy, 0);
    cyc();
    chk("rs_tid", sb_tid, 1);
    chk("rs_mvalid2", sb_mv, 1);
    drain();

    do_reset();
    for (int k = 0; k < N; k++) begin
      rpt[k] = 3;
      send(k, 1);
    end
    for (int i = 0; i < 100 && ord.size() < 8; i++) cyc();
    chk("all_count", ord.size() >= 8, 1);
    for (int i = 0; i < 8 && i < ord.size(); i++) chk($sformatf("all_ord%0d", i), ord[i], exp_all[i]);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
